// File: rtl/game_tick_gen.sv
// Multi-channel frame-rate tick generator. It detects each frame end from the scanner
// coordinates, then divides frame events down per channel with runtime divisors.
module game_tick_gen #(
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int X_LAST      = 39,
  parameter int Y_LAST      = 29,
  parameter int NUM_CH      = 2,
  parameter int SEL_W       = 1,
  parameter int DIV_W       = 4,
  parameter int DIV_DEFAULT = 6,
  parameter int FRAME_W     = 16
) (
  input  logic               in_clk,
  input  logic               reset,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic               pause,
  input  logic               step,
  input  logic               div_wr,
  input  logic [SEL_W-1:0]   div_sel,
  input  logic [DIV_W-1:0]   div_data,
  output logic [NUM_CH-1:0]  tick,
  output logic               frame_pulse,
  output logic [FRAME_W-1:0] frame_cnt
);

  logic               r_eof_d;
  logic               r_step_pend;
  logic               r_frame_pulse;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [NUM_CH-1:0]  r_tick;
  logic [DIV_W-1:0]   r_div [NUM_CH];
  logic [DIV_W-1:0]   r_cnt [NUM_CH];

  logic               w_eof_raw;
  logic               w_fe;
  logic               w_step_fire;
  logic               w_step_pend_nxt;
  logic [NUM_CH-1:0]  w_tick_nxt;
  logic [DIV_W-1:0]   w_div_nxt [NUM_CH];
  logic [DIV_W-1:0]   w_cnt_nxt [NUM_CH];

  assign w_eof_raw   = (x_in == X_W'(X_LAST)) && (y_in == Y_W'(Y_LAST));
  // A dwell on the last cell yields a single event; only the rising edge counts.
  assign w_fe        = w_eof_raw & ~r_eof_d;
  assign w_step_fire = w_fe & pause & r_step_pend;

  // Pending single-step request: only meaningful while paused, consumed by a frame event.
  always_comb begin
    w_step_pend_nxt = r_step_pend;
    if (!pause) begin
      w_step_pend_nxt = 1'b0;
    end else if (w_step_fire) begin
      w_step_pend_nxt = 1'b0;
    end else if (step) begin
      w_step_pend_nxt = 1'b1;
    end else begin
      w_step_pend_nxt = r_step_pend;
    end
  end

  // Per-channel divisor, frame counter and tick; a divisor write overrides everything else.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_div_nxt[i]  = r_div[i];
      w_cnt_nxt[i]  = r_cnt[i];
      w_tick_nxt[i] = 1'b0;
      if (div_wr && (div_sel == SEL_W'(i))) begin
        w_div_nxt[i] = div_data;
        w_cnt_nxt[i] = {DIV_W{1'b0}};
      end else if (r_div[i] == {DIV_W{1'b0}}) begin
        w_cnt_nxt[i] = {DIV_W{1'b0}};
      end else if (w_fe && !pause) begin
        if (r_cnt[i] == (r_div[i] - DIV_W'(1))) begin
          w_cnt_nxt[i]  = {DIV_W{1'b0}};
          w_tick_nxt[i] = 1'b1;
        end else begin
          w_cnt_nxt[i]  = r_cnt[i] + DIV_W'(1);
        end
      end else if (w_step_fire) begin
        w_cnt_nxt[i]  = {DIV_W{1'b0}};
        w_tick_nxt[i] = 1'b1;
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  // State registers; eof_d resets high so releasing reset on the last cell is not a frame end.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      r_eof_d       <= 1'b1;
      r_step_pend   <= 1'b0;
      r_frame_pulse <= 1'b0;
      r_frame_cnt   <= {FRAME_W{1'b0}};
      r_tick        <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        r_div[i] <= DIV_W'(DIV_DEFAULT);
        r_cnt[i] <= {DIV_W{1'b0}};
      end
    end else begin
      r_eof_d       <= w_eof_raw;
      r_step_pend   <= w_step_pend_nxt;
      r_frame_pulse <= w_fe;
      r_tick        <= w_tick_nxt;
      if (w_fe) begin
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        r_div[i] <= w_div_nxt[i];
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign tick        = r_tick;
  assign frame_pulse = r_frame_pulse;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_game_tick_gen.sv
// Bench for game_tick_gen: directed table, scenario sequences and randomized traffic
// compared against a frame-level reference model.
module tb_game_tick_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  x_i, y_i;
  logic        pause_i, step_i, wr_i;
  logic [0:0]  sel_i;
  logic [3:0]  data_i;
  logic [1:0]  tick_o;
  logic        fp_o;
  logic [15:0] fcnt_o;

  always #5 clk = ~clk;

  game_tick_gen dut (
    .in_clk(clk), .reset(rst_n), .x_in(x_i), .y_in(y_i), .pause(pause_i), .step(step_i),
    .div_wr(wr_i), .div_sel(sel_i), .div_data(data_i),
    .tick(tick_o), .frame_pulse(fp_o), .frame_cnt(fcnt_o)
  );

  int checks = 0;
  int failures = 0;

  // reference model: frames seen, per-channel phase within its divisor period
  bit   m_prev;
  int   m_frames;
  int   m_div [2];
  int   m_phase [2];
  bit   m_pend;
  logic [1:0] m_tick;
  bit   m_pulse;
  bit   cur_pause;

  typedef struct {
    int x; int y; bit p; bit s; bit w; int sel; int d;
    logic [1:0] et; bit ep; int ec;
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b1; m_frames = 0; m_pend = 1'b0; m_tick = 2'b00; m_pulse = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_div[c] = 6; m_phase[c] = 0;
    end
  endtask

  task automatic model_step(input int xv, input int yv, input bit p, input bit s,
                            input bit w, input int sel, input int d);
    bit at_last, fe, fire;
    at_last = (xv == 39) && (yv == 29);
    fe      = at_last && !m_prev;
    m_prev  = at_last;
    fire    = fe && p && m_pend;
    m_pulse = fe;
    if (fe) m_frames++;
    for (int c = 0; c < 2; c++) begin
      m_tick[c] = 1'b0;
      if (w && sel == c) begin
        m_div[c] = d; m_phase[c] = 0;
      end else if (m_div[c] == 0) begin
        m_phase[c] = 0;
      end else if (fe && !p) begin
        m_phase[c] = (m_phase[c] + 1) % m_div[c];
        m_tick[c]  = (m_phase[c] == 0);
      end else if (fire) begin
        m_phase[c] = 0; m_tick[c] = 1'b1;
      end
    end
    if (!p) m_pend = 1'b0;
    else if (fire) m_pend = 1'b0;
    else if (s) m_pend = 1'b1;
  endtask

  task automatic apply(input int xv, input int yv, input bit p, input bit s,
                       input bit w, input int sel, input int d);
    x_i = 10'(xv); y_i = 10'(yv); pause_i = p; step_i = s; wr_i = w;
    sel_i = 1'(sel); data_i = 4'(d);
    @(posedge clk);
    model_step(xv, yv, p, s, w, sel, d);
    #1;
    check("tick", int'(tick_o), int'(m_tick));
    check("frame_pulse", int'(fp_o), int'(m_pulse));
    check("frame_cnt", int'(fcnt_o), m_frames % 65536);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_tick", int'(tick_o), 0);
    check("rst_frame_pulse", int'(fp_o), 0);
    check("rst_frame_cnt", int'(fcnt_o), 0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic scan_frame(output logic [1:0] t);
    apply(0, 0, cur_pause, 1'b0, 1'b0, 0, 0);
    apply(39, 29, cur_pause, 1'b0, 1'b0, 0, 0);
    t = tick_o;
  endtask

  initial begin
    logic [1:0] t;
    logic [1:0] anyt;
    int mask0, mask1, n, c0, c1, start;
    int rx, ry, rs, rw, rsel, rd;
    bit rp;

    rst_n = 1'b0; x_i = '0; y_i = '0; pause_i = 1'b0; step_i = 1'b0;
    wr_i = 1'b0; sel_i = '0; data_i = '0; cur_pause = 1'b0;

    //            x   y  p  s  w sel d  tick  pulse fcnt
    tbl[0]  = '{  0,  0, 0, 0, 0, 0, 0, 2'b00, 0, 0};
    tbl[1]  = '{  0,  0, 0, 0, 1, 0, 1, 2'b00, 0, 0};
    tbl[2]  = '{  0,  0, 0, 0, 1, 1, 2, 2'b00, 0, 0};
    tbl[3]  = '{ 39, 29, 0, 0, 0, 0, 0, 2'b01, 1, 1};
    tbl[4]  = '{ 39, 29, 0, 0, 0, 0, 0, 2'b00, 0, 1};
    tbl[5]  = '{  0,  0, 0, 0, 0, 0, 0, 2'b00, 0, 1};
    tbl[6]  = '{ 39, 29, 0, 0, 0, 0, 0, 2'b11, 1, 2};
    tbl[7]  = '{ 39,  0, 0, 0, 0, 0, 0, 2'b00, 0, 2};
    tbl[8]  = '{ 39, 29, 0, 0, 1, 1, 0, 2'b01, 1, 3};
    tbl[9]  = '{  0,  0, 0, 0, 0, 0, 0, 2'b00, 0, 3};
    tbl[10] = '{ 39, 29, 1, 0, 0, 0, 0, 2'b00, 1, 4};
    tbl[11] = '{  0,  0, 1, 1, 0, 0, 0, 2'b00, 0, 4};
    tbl[12] = '{ 39, 29, 1, 0, 0, 0, 0, 2'b01, 1, 5};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].x, tbl[i].y, tbl[i].p, tbl[i].s, tbl[i].w, tbl[i].sel, tbl[i].d);
      check($sformatf("tbl%0d_tick", i), int'(tick_o), int'(tbl[i].et));
      check($sformatf("tbl%0d_pulse", i), int'(fp_o), int'(tbl[i].ep));
      check($sformatf("tbl%0d_fcnt", i), int'(fcnt_o), tbl[i].ec);
    end

    // default divisor: ticks on frames 6 and 12 of 13
    do_reset();
    mask0 = 0; mask1 = 0;
    for (int f = 1; f <= 13; f++) begin
      scan_frame(t);
      if (t[0]) mask0 |= (1 << f);
      if (t[1]) mask1 |= (1 << f);
    end
    check("def_ch0_frames", mask0, 32'h1040);
    check("def_ch1_frames", mask1, 32'h1040);
    check("def_frame_cnt", int'(fcnt_o), 13);

    // dwell on the last cell for 5 cycles
    apply(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    start = int'(fcnt_o); n = 0;
    for (int k = 0; k < 5; k++) begin
      apply(39, 29, 1'b0, 1'b0, 1'b0, 0, 0);
      n += int'(fp_o);
    end
    check("dwell_pulses", n, 1);
    check("dwell_cnt_delta", int'(fcnt_o) - start, 1);

    // ch1 divisor rewritten to 2 after frame 3
    do_reset();
    mask0 = 0; mask1 = 0;
    for (int f = 1; f <= 13; f++) begin
      if (f == 4) apply(0, 0, 1'b0, 1'b0, 1'b1, 1, 2);
      scan_frame(t);
      if (t[0]) mask0 |= (1 << f);
      if (t[1]) mask1 |= (1 << f);
    end
    check("wr_ch0_frames", mask0, 32'h1040);
    check("wr_ch1_frames", mask1, 32'h2AA0);

    // pause for 10 frames then single step
    do_reset();
    for (int f = 0; f < 4; f++) scan_frame(t);
    cur_pause = 1'b1; anyt = 2'b00;
    for (int f = 0; f < 10; f++) begin
      scan_frame(t);
      anyt |= t;
    end
    apply(0, 0, 1'b1, 1'b1, 1'b0, 0, 0);
    apply(0, 0, 1'b1, 1'b1, 1'b0, 0, 0);
    scan_frame(t);
    check("pause_no_ticks", int'(anyt), 0);
    check("step_tick", int'(t), 3);
    check("pause_frame_cnt", int'(fcnt_o), 15);
    cur_pause = 1'b0;

    // ch0 disabled for 20 frames
    do_reset();
    apply(0, 0, 1'b0, 1'b0, 1'b1, 0, 0);
    c0 = 0; c1 = 0;
    for (int f = 0; f < 20; f++) begin
      scan_frame(t);
      c0 += int'(t[0]);
      c1 += int'(t[1]);
    end
    check("dis_ch0_ticks", c0, 0);
    check("dis_ch1_ticks", c1, 3);

    // reset while parked on the last cell
    apply(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    apply(39, 29, 1'b0, 1'b0, 1'b0, 0, 0);
    do_reset();
    n = 0;
    for (int k = 0; k < 3; k++) begin
      apply(39, 29, 1'b0, 1'b0, 1'b0, 0, 0);
      n += int'(fp_o);
    end
    check("rstlast_pulses", n, 0);
    apply(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    apply(39, 29, 1'b0, 1'b0, 1'b0, 0, 0);
    check("rstlast_return_pulse", int'(fp_o), 1);
    check("rstlast_return_cnt", int'(fcnt_o), 1);

    // randomized traffic against the model
    do_reset();
    rp = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) rp = ~rp;
      case ($urandom_range(0, 3))
        0, 1:    begin rx = 39; ry = 29; end
        2:       begin rx = 39; ry = int'($urandom_range(0, 29)); end
        default: begin rx = int'($urandom_range(0, 39)); ry = int'($urandom_range(0, 29)); end
      endcase
      rs   = ($urandom_range(0, 9) == 0) ? 1 : 0;
      rw   = ($urandom_range(0, 39) == 0) ? 1 : 0;
      rsel = int'($urandom_range(0, 1));
      rd   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      apply(rx, ry, rp, rs[0], rw[0], rsel, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
